load_state: RTL and testbench
=============================

LOAD_STATE -- requirements
Module: load_state

Interface
REQ-001 clk  input  1  system clock; all logic on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 fill_start  input  1  single-cycle request to restore one physical channel's state.
REQ-004 fill_abort  input  1  synchronous abort of the fill in progress.
REQ-005 physical_channel_index  input  2  target channel; sampled only on an accepted fill_start.
REQ-006 state_rd  output  1  state-buffer read strobe.
REQ-007 state_addr  output  5  state-buffer word address.
REQ-008 state_rdata  input  32  state-buffer read data; valid exactly 1 cycle after state_rd.
REQ-009 fill_busy  output  1  high while a fill is in progress.
REQ-010 fill_done  output  1  one-cycle pulse on completion.
REQ-011 ld_ch  output  4  one-hot target channel; qualifies every ld_* strobe.
REQ-012 ld_prn_state, ld_prn_count, ld_carrier_phase, ld_carrier_count, ld_code_phase, ld_prn_code, ld_cor_state, ld_ms_data_sum, ld_prn2_state, ld_iq_acc  output  1 each  field load strobes.
REQ-013 ld_data  output  32  registered state word for the active strobe.
REQ-014 Decoded outputs, all taken from ld_data:
- dump_count[15:0]=31:16, jump_count[7:0]=15:8, prn_code[7:0]=7:0.
- nh_count[4:0]=31:27, coherent_count[4:0]=25:21, ms_data_count[4:0]=20:16, prn_code2[3:0]=15:12.
- code_sub_phase=8, dumping=7, current_cor[2:0]=6:4, msdata_done=1, coherent_done=0.
- ms_data_sum[15:0]=15:0, i_acc[15:0]=31:16, q_acc[15:0]=15:0.

Function
REQ-015 FSM states: IDLE, READ, DRAIN.
- IDLE->READ on fill_start.
- READ->DRAIN after the 10th read is issued.
- DRAIN->IDLE when fill_done is asserted.
REQ-016 Read sequence: one read per cycle, no gaps, at state_addr 6,7,8,9,10,11,12,13,15,16 in that order; address 14 and all other addresses are never issued.
REQ-017 Field mapping, one per address in REQ-016 order: prn_state, prn_count, carrier_phase, carrier_count, code_phase, prn_code, cor_state, ms_data_sum, prn2_state, iq_acc.
REQ-018 Timing, with fill_start accepted in cycle T:
- reads are issued in cycles T+1..T+10;
- ld_data and the matching strobe are registered and valid in cycles T+3..T+12;
- at most one strobe is high in any cycle.
REQ-019 fill_done is asserted in T+12, coincident with ld_iq_acc. fill_busy is high T+1..T+12 inclusive.
REQ-020 ld_ch = one-hot of physical_channel_index latched at T; it is held constant for the whole fill and is 4'b0000 whenever no strobe is high.
REQ-021 fill_start is ignored while fill_busy=1, including the fill_done cycle; the latched channel index does not change.
REQ-022 fill_abort while busy:
- next cycle the FSM is IDLE, with state_rd, all strobes, fill_busy and ld_ch at 0;
- the read data still in flight is discarded;
- no fill_done is produced.
REQ-023 fill_abort in IDLE has no effect. fill_abort and fill_start in the same IDLE cycle: abort wins, the start is dropped.
REQ-024 state_addr holds 0 whenever state_rd=0.
REQ-025 No arithmetic on data: ld_data is state_rdata delayed by one register, bit-exact.

Reset
REQ-026 rst=1 forces IDLE in the next cycle. Every output goes to 0: state_rd, state_addr, fill_busy, fill_done, ld_ch, all strobes, ld_data.
REQ-027 rst mid-fill behaves as REQ-022 and additionally clears ld_data and the latched channel index.
REQ-028 The first fill_start is accepted in the first cycle after rst deasserts.

Verification
REQ-029 Nominal fill:
- stimulus: index=2, memory word at address a = 32'hA000_0000+a, fill_start at T;
- required: reads at 6..13,15,16 in T+1..T+10; ld_ch=4'b0100; ld_prn_state with ld_data=32'hA000_0006 at T+3; ld_iq_acc with 32'hA000_0010 at T+12; fill_done at T+12.
REQ-030 Decode check:
- stimulus: cor_state word 32'hF9FF_F1F3 on channel 0;
- required: nh_count=31, coherent_count=15, ms_data_count=31, prn_code2=15, code_sub_phase=1, dumping=1, current_cor=7, msdata_done=1, coherent_done=1.
REQ-031 Busy start: second fill_start at T+5 with index=3 -> ignored; ld_ch stays at the original channel; exactly one fill_done.
REQ-032 Abort: fill_abort at T+6 -> no strobe from T+7; fill_busy=0 at T+7; no fill_done; a new fill_start at T+7 runs a full, correct sequence.
REQ-033 Reset mid-fill: rst at T+4 -> all outputs 0 at T+5 and no later strobes; back-to-back fills starting at T+13 and T+26 each produce 10 strobes and one fill_done.

Source files
------------

// File: rtl/load_state_if.sv
// Signal bundle for load_state: fill control, state-buffer read port, field
// load strobes and the decoded views of the loaded word.
// The master modport is the load_state side; slave is the surrounding logic.
interface load_state_if;
    logic        fill_start;
    logic        fill_abort;
    logic [1:0]  physical_channel_index;
    logic        fill_busy;
    logic        fill_done;

    logic        state_rd;
    logic [4:0]  state_addr;
    logic [31:0] state_rdata;

    logic [3:0]  ld_ch;
    logic        ld_prn_state;
    logic        ld_prn_count;
    logic        ld_carrier_phase;
    logic        ld_carrier_count;
    logic        ld_code_phase;
    logic        ld_prn_code;
    logic        ld_cor_state;
    logic        ld_ms_data_sum;
    logic        ld_prn2_state;
    logic        ld_iq_acc;
    logic [31:0] ld_data;

    logic [15:0] dump_count;
    logic [7:0]  jump_count;
    logic [7:0]  prn_code;
    logic [4:0]  nh_count;
    logic [4:0]  coherent_count;
    logic [4:0]  ms_data_count;
    logic [3:0]  prn_code2;
    logic        code_sub_phase;
    logic        dumping;
    logic [2:0]  current_cor;
    logic        msdata_done;
    logic        coherent_done;
    logic [15:0] ms_data_sum;
    logic [15:0] i_acc;
    logic [15:0] q_acc;

    modport master (
        input  fill_start, fill_abort, physical_channel_index, state_rdata,
        output fill_busy, fill_done, state_rd, state_addr,
        output ld_ch, ld_prn_state, ld_prn_count, ld_carrier_phase, ld_carrier_count,
        output ld_code_phase, ld_prn_code, ld_cor_state, ld_ms_data_sum, ld_prn2_state,
        output ld_iq_acc, ld_data,
        output dump_count, jump_count, prn_code, nh_count, coherent_count, ms_data_count,
        output prn_code2, code_sub_phase, dumping, current_cor, msdata_done, coherent_done,
        output ms_data_sum, i_acc, q_acc
    );

    modport slave (
        output fill_start, fill_abort, physical_channel_index, state_rdata,
        input  fill_busy, fill_done, state_rd, state_addr,
        input  ld_ch, ld_prn_state, ld_prn_count, ld_carrier_phase, ld_carrier_count,
        input  ld_code_phase, ld_prn_code, ld_cor_state, ld_ms_data_sum, ld_prn2_state,
        input  ld_iq_acc, ld_data,
        input  dump_count, jump_count, prn_code, nh_count, coherent_count, ms_data_count,
        input  prn_code2, code_sub_phase, dumping, current_cor, msdata_done, coherent_done,
        input  ms_data_sum, i_acc, q_acc
    );
endinterface

// File: rtl/load_state.sv
// Restores one physical channel's tracking state from the state buffer:
// ten back-to-back reads, each word re-registered and handed out with its
// field strobe and the one-hot target channel.
module load_state (
    input  logic          clk,
    input  logic          rst,
    load_state_if.master  bus
);

    typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

    state_e      state_q, state_d;
    logic [3:0]  rd_cnt_q;
    logic [1:0]  ch_q;
    logic        pend_q;       // a read issued last cycle has data on state_rdata now
    logic [3:0]  pend_idx_q;
    logic [9:0]  ld_q;         // one bit per field, in read order
    logic [31:0] ld_data_q;

    logic busy;
    logic rd_en;
    logic abort;
    logic start_ok;

    assign busy     = (state_q != StIdle);
    assign rd_en    = (state_q == StRead);
    assign abort    = busy && bus.fill_abort;
    // Abort beats a simultaneous start in idle.
    assign start_ok = (state_q == StIdle) && bus.fill_start && !bus.fill_abort;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_ok)          state_d = StRead;
            StRead:  if (rd_cnt_q == 4'd9)  state_d = StDrain;
            StDrain: if (ld_q[9])           state_d = StIdle;
            default:                        state_d = StIdle;
        endcase
        if (abort) state_d = StIdle;
    end

    // Read-issue counter, one-cycle data pipeline and strobe/data registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q   <= 4'd0;
            ch_q       <= 2'd0;
            pend_q     <= 1'b0;
            pend_idx_q <= 4'd0;
            ld_q       <= 10'd0;
            ld_data_q  <= 32'd0;
        end else begin
            if (start_ok) ch_q <= bus.physical_channel_index;
            rd_cnt_q   <= (rd_en && !abort) ? rd_cnt_q + 4'd1 : 4'd0;
            pend_q     <= rd_en && !abort;
            pend_idx_q <= rd_cnt_q;
            ld_q       <= (pend_q && !abort) ? (10'd1 << pend_idx_q) : 10'd0;
            if (pend_q && !abort) ld_data_q <= bus.state_rdata;
        end
    end

    // Read port: addresses 6..13 then 15,16 (14 is skipped).
    always_comb begin
        bus.state_rd   = rd_en;
        bus.state_addr = 5'd0;
        if (rd_en) begin
            bus.state_addr = (rd_cnt_q < 4'd8) ? {1'b0, rd_cnt_q} + 5'd6
                                               : {1'b0, rd_cnt_q} + 5'd7;
        end
    end

    assign bus.fill_busy        = busy;
    assign bus.fill_done        = ld_q[9];
    assign bus.ld_ch            = (ld_q != 10'd0) ? (4'd1 << ch_q) : 4'd0;
    assign bus.ld_prn_state     = ld_q[0];
    assign bus.ld_prn_count     = ld_q[1];
    assign bus.ld_carrier_phase = ld_q[2];
    assign bus.ld_carrier_count = ld_q[3];
    assign bus.ld_code_phase    = ld_q[4];
    assign bus.ld_prn_code      = ld_q[5];
    assign bus.ld_cor_state     = ld_q[6];
    assign bus.ld_ms_data_sum   = ld_q[7];
    assign bus.ld_prn2_state    = ld_q[8];
    assign bus.ld_iq_acc        = ld_q[9];
    assign bus.ld_data          = ld_data_q;

    // Field views of the loaded word; consumers qualify them with the strobes.
    assign bus.dump_count     = ld_data_q[31:16];
    assign bus.jump_count     = ld_data_q[15:8];
    assign bus.prn_code       = ld_data_q[7:0];
    assign bus.nh_count       = ld_data_q[31:27];
    assign bus.coherent_count = ld_data_q[25:21];
    assign bus.ms_data_count  = ld_data_q[20:16];
    assign bus.prn_code2      = ld_data_q[15:12];
    assign bus.code_sub_phase = ld_data_q[8];
    assign bus.dumping        = ld_data_q[7];
    assign bus.current_cor    = ld_data_q[6:4];
    assign bus.msdata_done    = ld_data_q[1];
    assign bus.coherent_done  = ld_data_q[0];
    assign bus.ms_data_sum    = ld_data_q[15:0];
    assign bus.i_acc          = ld_data_q[31:16];
    assign bus.q_acc          = ld_data_q[15:0];

endmodule

// File: tb/tb_load_state.sv
// Bench for load_state: directed scenarios with literal expectations plus a
// random run, all compared every cycle against a fill-offset model.
module tb_load_state;

    logic clk;
    logic rst;
    load_state_if bus ();

    load_state dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [32];
    int          addrs [10] = '{6, 7, 8, 9, 10, 11, 12, 13, 15, 16};

    // Model: a fill is "active" with offset m_k = cycles since acceptance.
    logic        m_active = 1'b0;
    int          m_k = 0;
    logic [1:0]  m_ch = 2'd0;
    logic [31:0] m_words [10];
    logic        m_zero = 1'b0;

    logic        smp_rd = 1'b0;
    logic [4:0]  smp_addr = 5'd0;

    logic [9:0] o_stb;
    assign o_stb = {bus.ld_iq_acc, bus.ld_prn2_state, bus.ld_ms_data_sum, bus.ld_cor_state,
                    bus.ld_prn_code, bus.ld_code_phase, bus.ld_carrier_count,
                    bus.ld_carrier_phase, bus.ld_prn_count, bus.ld_prn_state};

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // State buffer: answers exactly one cycle after a read, noise otherwise.
    always @(posedge clk) begin
        #1;
        bus.state_rdata = smp_rd ? mem[smp_addr] : $urandom;
    end

    // Every-cycle compare against the model, then advance the model.
    always @(negedge clk) begin
        logic       e_rd;
        logic [4:0] e_addr;
        logic [9:0] e_stb;
        logic [3:0] e_ch;
        logic [31:0] w;
        smp_rd   = bus.state_rd;
        smp_addr = bus.state_addr;

        e_rd   = m_active && (m_k <= 10);
        e_addr = e_rd ? 5'(addrs[m_k - 1]) : 5'd0;
        e_stb  = (m_active && m_k >= 3) ? (10'd1 << (m_k - 3)) : 10'd0;
        e_ch   = (e_stb != 10'd0) ? (4'd1 << m_ch) : 4'd0;
        chk("ctl", 128'({bus.state_rd, bus.state_addr, bus.fill_busy, bus.fill_done,
                         bus.ld_ch, o_stb}),
                   128'({e_rd, e_addr, m_active, m_active && (m_k == 12), e_ch, e_stb}));
        if (m_active && m_k >= 3) begin
            w = m_words[m_k - 3];
            chk("ld_data", 128'(bus.ld_data), 128'(w));
            chk("decode",
                128'({bus.dump_count, bus.jump_count, bus.prn_code, bus.nh_count,
                      bus.coherent_count, bus.ms_data_count, bus.prn_code2,
                      bus.code_sub_phase, bus.dumping, bus.current_cor, bus.msdata_done,
                      bus.coherent_done, bus.ms_data_sum, bus.i_acc, bus.q_acc}),
                128'({w[31:16], w[15:8], w[7:0], w[31:27], w[25:21], w[20:16], w[15:12],
                      w[8], w[7], w[6:4], w[1], w[0], w[15:0], w[31:16], w[15:0]}));
        end
        if (m_zero) chk("rst_ld_data", 128'(bus.ld_data), 128'(0));

        if (rst) begin
            m_active = 1'b0;
            m_k      = 0;
            m_zero   = 1'b1;
        end else begin
            m_zero = 1'b0;
            if (m_active) begin
                if (bus.fill_abort || m_k == 12) m_active = 1'b0;
                else m_k++;
            end else if (bus.fill_start && !bus.fill_abort) begin
                m_active = 1'b1;
                m_k      = 1;
                m_ch     = bus.physical_channel_index;
                for (int i = 0; i < 10; i++) m_words[i] = mem[addrs[i]];
            end
        end
    end

    task automatic tick(input logic s, input logic a, input logic r, input logic [1:0] idx);
        @(posedge clk);
        #1;
        bus.fill_start             = s;
        bus.fill_abort             = a;
        rst                        = r;
        bus.physical_channel_index = idx;
    endtask

    task automatic window(input int n, output int sc, output int dc);
        sc = 0;
        dc = 0;
        for (int i = 0; i < n; i++) begin
            tick(1'b0, 1'b0, 1'b0, 2'd0);
            @(negedge clk);
            sc += $countones(o_stb);
            dc += int'(bus.fill_done);
        end
    endtask

    initial begin
        int sc;
        int dc;
        rst = 1'b1;
        bus.fill_start = 1'b0;
        bus.fill_abort = 1'b0;
        bus.physical_channel_index = 2'd0;
        for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + 32'(i);

        tick(1'b0, 1'b0, 1'b1, 2'd0);
        tick(1'b0, 1'b0, 1'b1, 2'd0);
        @(negedge clk);
        chk("reset_outs", 128'({bus.fill_busy, bus.fill_done, bus.state_rd, bus.state_addr,
                                bus.ld_ch, o_stb, bus.ld_data}), 128'(0));

        // Nominal fill on channel 2, started right after reset; busy start at T+5.
        tick(1'b1, 1'b0, 1'b0, 2'd2);
        dc = 0;
        for (int k = 1; k <= 13; k++) begin
            tick(k == 5, 1'b0, 1'b0, (k == 5) ? 2'd3 : 2'd0);
            @(negedge clk);
            dc += int'(bus.fill_done);
            if (k == 1) chk("first_addr", 128'({bus.state_rd, bus.state_addr}),
                            128'({1'b1, 5'd6}));
            if (k == 9) chk("addr_skip14", 128'({bus.state_rd, bus.state_addr}),
                            128'({1'b1, 5'd15}));
            if (k == 3) chk("nom_first", 128'({bus.ld_prn_state, bus.ld_ch, bus.ld_data}),
                            128'({1'b1, 4'b0100, 32'hA000_0006}));
            if (k == 12) chk("nom_last", 128'({bus.ld_iq_acc, bus.fill_done, bus.ld_ch,
                                               bus.ld_data}),
                             128'({1'b1, 1'b1, 4'b0100, 32'hA000_0010}));
            if (k == 13) chk("nom_idle", 128'({bus.fill_busy, bus.state_rd}), 128'(0));
        end
        chk("busy_start_one_done", 128'(dc), 128'(1));

        // Decode of a cor_state word on channel 0.
        mem[12] = 32'hF9FF_F1F3;
        tick(1'b1, 1'b0, 1'b0, 2'd0);
        for (int k = 1; k <= 12; k++) begin
            tick(1'b0, 1'b0, 1'b0, 2'd0);
            @(negedge clk);
            if (k == 9) chk("decode_cor",
                128'({bus.ld_cor_state, bus.ld_ch, bus.nh_count, bus.coherent_count,
                      bus.ms_data_count, bus.prn_code2, bus.code_sub_phase, bus.dumping,
                      bus.current_cor, bus.msdata_done, bus.coherent_done}),
                128'({1'b1, 4'b0001, 5'd31, 5'd15, 5'd31, 4'd15, 1'b1, 1'b1, 3'd7,
                      1'b1, 1'b1}));
        end

        // Abort at T+6, restart at T+7.
        tick(1'b1, 1'b0, 1'b0, 2'd1);
        for (int k = 1; k <= 6; k++) tick(1'b0, k == 6, 1'b0, 2'd0);
        tick(1'b1, 1'b0, 1'b0, 2'd3);
        @(negedge clk);
        chk("abort_idle", 128'({bus.fill_busy, bus.fill_done, bus.state_rd, bus.ld_ch, o_stb}),
            128'(0));
        window(12, sc, dc);
        chk("abort_restart_stb", 128'(sc), 128'(10));
        chk("abort_restart_done", 128'(dc), 128'(1));

        // Reset at T+4, then fills at T+13 and T+26.
        tick(1'b1, 1'b0, 1'b0, 2'd2);
        for (int k = 1; k <= 4; k++) tick(1'b0, 1'b0, k == 4, 2'd0);
        tick(1'b0, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        chk("midrst_zero", 128'({bus.fill_busy, bus.fill_done, bus.state_rd, bus.state_addr,
                                 bus.ld_ch, o_stb, bus.ld_data}), 128'(0));
        window(7, sc, dc);
        chk("midrst_quiet", 128'(sc + dc), 128'(0));
        tick(1'b1, 1'b0, 1'b0, 2'd1);
        window(12, sc, dc);
        chk("b2b_first", 128'({sc, dc}), 128'({32'd10, 32'd1}));
        tick(1'b1, 1'b0, 1'b0, 2'd0);
        window(12, sc, dc);
        chk("b2b_second", 128'({sc, dc}), 128'({32'd10, 32'd1}));

        // Random traffic; model checks every cycle.
        for (int c = 0; c < 4000; c++) begin
            logic s;
            logic a;
            logic r;
            s = ($urandom_range(0, 5) == 0);
            a = ($urandom_range(0, 39) == 0);
            r = ($urandom_range(0, 149) == 0);
            if (!m_active && s && ($urandom_range(0, 1) == 1)) begin
                for (int i = 0; i < 32; i++) mem[i] = $urandom;
            end
            tick(s, a, r, 2'($urandom_range(0, 3)));
        end
        tick(1'b0, 1'b0, 1'b0, 2'd0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
